// File: rtl/sync_register_arbiter.sv
// sync_register_arbiter: round-robin sharing of one SyncRegister source port among NCLIENT coalescing posters.
// Optional SYNC_ARB_OVERWRITE_CNT_EN adds per-client saturating overwrite counters on ovw_cnt.
module sync_register_arbiter #(
  parameter int NCLIENT = 4,
  parameter int DWIDTH  = 8,
  parameter int IDWIDTH = 2
) (
  input  logic                        sCLK,
  input  logic                        sRST,
  input  logic [NCLIENT-1:0]          cli_wr,
  input  logic [NCLIENT*DWIDTH-1:0]   cli_data,
  output logic [NCLIENT-1:0]          cli_pend,
  output logic [NCLIENT-1:0]          cli_done,
  output logic                        sync_en,
  output logic [IDWIDTH+DWIDTH-1:0]   sync_d,
  input  logic                        sync_rdy,
  output logic                        arb_idle
`ifdef SYNC_ARB_OVERWRITE_CNT_EN
  ,
  output logic [NCLIENT*8-1:0]        ovw_cnt
`endif
);
  typedef enum logic {IDLE, GUARD} state_t;
  state_t state_q, state_d;
  logic [NCLIENT-1:0] pend_q, pend_d, win_oh;
  logic [DWIDTH-1:0] slot_q [NCLIENT];
  logic [DWIDTH-1:0] slot_d [NCLIENT];
  logic [IDWIDTH-1:0] rr_q, rr_d, win;
  logic found, issue;
  always_ff @(posedge sCLK) begin
    if (sRST) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == GUARD ? IDLE : issue ? GUARD : IDLE;
  end
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int i = 0; i < NCLIENT; i++) begin
      int idx;
      idx = (int'(rr_q) + i) % NCLIENT;
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        win = IDWIDTH'(idx);
      end
    end
  end
  always_comb begin
    issue = state_q == IDLE && sync_rdy && found;
    win_oh = issue ? NCLIENT'(1) << win : '0;
    pend_d = (pend_q & ~win_oh) | cli_wr;
    rr_d = issue ? IDWIDTH'((int'(win) + 1) % NCLIENT) : rr_q;
    for (int k = 0; k < NCLIENT; k++) slot_d[k] = cli_wr[k] ? cli_data[k*DWIDTH +: DWIDTH] : slot_q[k];
  end
  always_ff @(posedge sCLK) begin
    if (sRST) begin
      pend_q <= '0;
      rr_q <= '0;
      for (int k = 0; k < NCLIENT; k++) slot_q[k] <= '0;
    end else begin
      pend_q <= pend_d;
      rr_q <= rr_d;
      for (int k = 0; k < NCLIENT; k++) slot_q[k] <= slot_d[k];
    end
  end
  always_comb begin
    sync_en = issue;
    sync_d = issue ? {win, slot_q[win]} : '0;
    cli_done = win_oh;
    cli_pend = pend_q;
    arb_idle = pend_q == '0 && state_q == IDLE;
  end
`ifdef SYNC_ARB_OVERWRITE_CNT_EN
  logic [7:0] cnt_q [NCLIENT];
  logic [7:0] cnt_d [NCLIENT];
  // An overwrite of the slot being issued is not a loss: the old value still goes out.
  always_comb begin
    for (int k = 0; k < NCLIENT; k++) begin
      cnt_d[k] = cli_wr[k] && pend_q[k] && !win_oh[k] && cnt_q[k] != 8'hFF ? cnt_q[k] + 8'd1 : cnt_q[k];
      ovw_cnt[k*8 +: 8] = cnt_q[k];
    end
  end
  always_ff @(posedge sCLK) begin
    for (int k = 0; k < NCLIENT; k++) cnt_q[k] <= sRST ? 8'd0 : cnt_d[k];
  end
`endif
endmodule

// File: doc/sync_register_arbiter.md
Name: sync_register_arbiter

Overview:
- Shares one SyncRegister clock-domain crossing channel among NCLIENT source-domain requesters.
- Each client posts a value. The value is held in a per-client pending slot, so a newer post replaces an older one that has not yet been sent.
- A round-robin scheduler issues one pending slot at a time into the SyncRegister sEN/sD_IN/sRDY handshake. Each issued word is tagged with the client index so the destination side can demultiplex it.
- Sits entirely in the sCLK domain, directly in front of the SyncRegister source port.

Parameters:
- NCLIENT, 4, number of requesters (2..16)
- DWIDTH, 8, payload width per client
- IDWIDTH, 2, client-index tag width; must satisfy 2**IDWIDTH >= NCLIENT

Ports:
- sCLK  in  1  source-domain clock
- sRST  in  1  reset, synchronous, active-high; clock sCLK
- cli_wr  in  NCLIENT  per-client post strobe, one sCLK pulse per post
- cli_data  in  NCLIENT*DWIDTH  per-client payload; client k uses bits [k*DWIDTH +: DWIDTH]
- cli_pend  out  NCLIENT  per-client slot-pending flag
- cli_done  out  NCLIENT  one-cycle pulse when client k's slot is issued
- sync_en  out  1  drives SyncRegister sEN
- sync_d  out  IDWIDTH+DWIDTH  drives SyncRegister sD_IN as {client_id, payload}
- sync_rdy  in  1  from SyncRegister sRDY
- arb_idle  out  1  high when no slot is pending and the FSM is in IDLE

Behaviour:
- Reset (sRST=1 at a sCLK edge):
  - pend cleared, slot data cleared to 0, rr_ptr=0, FSM=IDLE.
  - Outputs: sync_en=0, sync_d=0, cli_done=0, cli_pend=0, arb_idle=1.
  - Reset mid-transfer abandons the transfer. No cli_done is produced. SyncRegister shares sRST, so both sides restart together.
- Posting:
  - cli_wr[k]=1 loads slot[k] from cli_data[k] and sets pend[k] on the next edge.
  - Posting to an already-pending slot overwrites the data; only the latest value is sent (coalescing).
- FSM states IDLE, GUARD:
  - IDLE: if sync_rdy=1 and any pend bit is set, select winner w = first set pend bit searching rr_ptr, rr_ptr+1, … mod NCLIENT.
  - In the same cycle, combinationally: sync_en=1, sync_d={w[IDWIDTH-1:0], slot[w]}, cli_done[w]=1.
  - Next edge: pend[w] cleared, rr_ptr=(w+1) mod NCLIENT, FSM→GUARD.
  - GUARD: lasts exactly 1 cycle. sync_en=0 and sync_rdy is ignored, which covers the registered drop of sRDY. Then FSM→IDLE.
  - IDLE with sync_rdy=0: wait; sync_en=0.
- Outputs outside an issue cycle: sync_en=0, sync_d=0, cli_done=0.
- Simultaneous events:
  - cli_wr[w] in the same cycle w is issued: the old slot value is sent, the new value is loaded, and pend[w] stays 1 (set wins over clear).
  - cli_wr on other clients during an issue: normal load.
- Throughput and latency:
  - At most one issue per GUARD+handshake period. Minimum gap is 2 sCLK when sync_rdy stays high; the real gap is set by sRDY recovery.
  - Latency from cli_wr to sync_en is ≥1 sCLK; the slot must be pending before the edge.
- Fairness: rr_ptr advances past the winner, so with all clients pending each client is served once per NCLIENT issues.
- cli_pend = pend. arb_idle = (pend==0) && FSM==IDLE.

Optional Feature:
- Macro SYNC_ARB_OVERWRITE_CNT_EN.
- When defined:
  - Extra port ovw_cnt out NCLIENT*8: per-client saturating 8-bit overwrite counter.
  - Counter k increments when cli_wr[k]=1 while pend[k]=1 and slot k is not being issued that cycle.
  - Saturates at 255; cleared by sRST.
- When not defined: no port and no counters; behaviour is otherwise identical.

Test Plan:
- Reset, then sync_rdy=1, cli_wr[2]=1 with data 0x5A → next cycle sync_en=1, sync_d={2'd2,8'h5A}, cli_done[2]=1; following cycle sync_en=0 (GUARD); arb_idle=1 after.
- All four clients post 0x10,0x11,0x12,0x13 in one cycle, sync_rdy held 1 → issues in order ids 0,1,2,3 every 2 cycles; then rr_ptr=0.
- sync_rdy=0, client 1 posts 0x01 then 0x02 → nothing issued; when sync_rdy=1 a single word {1,0x02} is sent. With SYNC_ARB_OVERWRITE_CNT_EN, ovw_cnt[1]=1.
- Client 3 posts 0xAA and is issued; in that same cycle it posts 0xBB → sync_d={3,0xAA}, pend[3] remains 1, a later issue sends {3,0xBB}.
- Clients 0 and 2 pending, sRST asserted in the GUARD cycle → all pend=0, arb_idle=1, no further sync_en or cli_done until new posts.
- Client 0 posts continuously every cycle, client 1 posts once → client 1 is issued no later than the 2nd issue after its post.
